// File: rtl/mdu_e_stage_pkg.sv
// Shared MDU definitions: op encodings, default latencies, FSM state type.
package mdu_e_stage_pkg;

  localparam logic [4:0] MDU_MULT  = 5'd0;
  localparam logic [4:0] MDU_MULTU = 5'd1;
  localparam logic [4:0] MDU_DIV   = 5'd2;
  localparam logic [4:0] MDU_DIVU  = 5'd3;
  localparam logic [4:0] MDU_MFHI  = 5'd4;
  localparam logic [4:0] MDU_MFLO  = 5'd5;
  localparam logic [4:0] MDU_MTHI  = 5'd6;
  localparam logic [4:0] MDU_MTLO  = 5'd7;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;
  localparam int unsigned MDU_CNT_W       = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_e_stage.sv
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency with a
// down-counter, and raises a stall for a following MDU instruction in D.
module mdu_e_stage
  import mdu_e_stage_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic        d_md_class,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out,
  output logic        stall_md
);

  mdu_state_e             r_state, w_state_next;
  logic [MDU_CNT_W-1:0]   r_cnt, w_cnt_next;
  logic                   r_busy, w_busy_next;
  logic [31:0]            r_hi, w_hi_next;
  logic [31:0]            r_lo, w_lo_next;
  logic [63:0]            r_pend, w_pend_next;
  logic                   r_nowrite, w_nowrite_next;

  logic [63:0] w_mul_s, w_mul_u;
  logic [31:0] w_rt_nz, w_quo_s, w_rem_s, w_quo_u, w_rem_u;
  logic        w_accept;

  // Divisor forced to 1 on divide-by-zero so the datapath never produces X;
  // the result is discarded via r_nowrite anyway.
  always_comb begin
    w_rt_nz = (rt_val == 32'd0) ? 32'd1 : rt_val;
    w_mul_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    w_mul_u = {32'd0, rs_val} * {32'd0, rt_val};
    w_quo_s = $signed(rs_val) / $signed(w_rt_nz);
    w_rem_s = $signed(rs_val) % $signed(w_rt_nz);
    w_quo_u = rs_val / w_rt_nz;
    w_rem_u = rs_val % w_rt_nz;
  end

  assign w_accept = start & ~cancel & ~r_busy;

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_busy_next    = r_busy;
    w_hi_next      = r_hi;
    w_lo_next      = r_lo;
    w_pend_next    = r_pend;
    w_nowrite_next = r_nowrite;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              w_pend_next    = (op == MDU_MULT) ? w_mul_s : w_mul_u;
              w_nowrite_next = 1'b0;
              w_cnt_next     = MDU_CNT_W'(MULT_CYCLES);
              w_busy_next    = 1'b1;
              w_state_next   = ST_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              w_pend_next    = (op == MDU_DIV) ? {w_rem_s, w_quo_s} : {w_rem_u, w_quo_u};
              w_nowrite_next = (rt_val == 32'd0);
              w_cnt_next     = MDU_CNT_W'(DIV_CYCLES);
              w_busy_next    = 1'b1;
              w_state_next   = ST_RUN;
            end
            MDU_MTHI: w_hi_next = rs_val;
            MDU_MTLO: w_lo_next = rs_val;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        w_cnt_next = r_cnt - MDU_CNT_W'(1);
        if (r_cnt == MDU_CNT_W'(1)) begin
          w_busy_next  = 1'b0;
          w_state_next = ST_IDLE;
          if (!r_nowrite) begin
            w_hi_next = r_pend[63:32];
            w_lo_next = r_pend[31:0];
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend    <= '0;
      r_nowrite <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_busy    <= w_busy_next;
      r_hi      <= w_hi_next;
      r_lo      <= w_lo_next;
      r_pend    <= w_pend_next;
      r_nowrite <= w_nowrite_next;
    end
  end

  always_comb begin
    md_out = 32'd0;
    if (op == MDU_MFHI)      md_out = r_hi;
    else if (op == MDU_MFLO) md_out = r_lo;
  end

  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign stall_md = d_md_class & (r_busy | (start & is_muldiv(op) & ~cancel));

endmodule

// File: tb/tb_mdu_e_stage.sv
// Directed bench for mdu_e_stage: vector table of single ops plus hand
// sequences for cancel, start-while-busy, unknown op and mid-op reset.
module tb_mdu_e_stage;

  localparam logic [4:0] OP_MULT  = 5'd0;
  localparam logic [4:0] OP_MULTU = 5'd1;
  localparam logic [4:0] OP_DIV   = 5'd2;
  localparam logic [4:0] OP_DIVU  = 5'd3;
  localparam logic [4:0] OP_MFHI  = 5'd4;
  localparam logic [4:0] OP_MFLO  = 5'd5;
  localparam logic [4:0] OP_MTHI  = 5'd6;
  localparam logic [4:0] OP_MTLO  = 5'd7;
  localparam logic [4:0] OP_NONE  = 5'd31;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op = OP_NONE;
  logic        d_md_class = 1'b0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, md_out;
  logic        stall_md;

  int checks = 0;
  int errors = 0;

  mdu_e_stage dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .d_md_class(d_md_class), .rs_val(rs_val), .rt_val(rt_val),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo),
    .md_out(md_out), .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles after the accept edge, with a hard bound.
  task automatic count_busy(output int n, output logic stall_ok);
    n = 0;
    stall_ok = 1'b1;
    while (busy === 1'b1 && n < 50) begin
      if (stall_md !== 1'b1) stall_ok = 1'b0;
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    logic stall_ok;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[5] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[7] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[8] = '{OP_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
    vecs[9] = '{OP_MTLO,  32'hCAFEBABE, 32'h0,        32'h12345678, 32'hCAFEBABE, 0};

    #2;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    step();
    reset_n = 1'b1;
    step();

    d_md_class = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; op = vecs[i].op; rs_val = vecs[i].rs; rt_val = vecs[i].rt;
      #1;
      check($sformatf("v%0d_stall_pre", i), {63'd0, stall_md}, {63'd0, vecs[i].exp_cyc != 0});
      step();
      start = 1'b0; op = OP_NONE;
      count_busy(n, stall_ok);
      check($sformatf("v%0d_busy_cycles", i), 64'(n), 64'(vecs[i].exp_cyc));
      check($sformatf("v%0d_stall_busy", i), {63'd0, stall_ok}, 64'd1);
      check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
      $display("vec %0d op=%0d rs=%h rt=%h busy=%0d hi=%h lo=%h", i, vecs[i].op,
               vecs[i].rs, vecs[i].rt, n, hi, lo);
    end
    d_md_class = 1'b0;

    // mfhi / mflo read path
    op = OP_MFHI; #1;
    check("mfhi_md_out", {32'd0, md_out}, 64'h12345678);
    check("mfhi_no_busy", {63'd0, busy}, 64'd0);
    op = OP_MFLO; #1;
    check("mflo_md_out", {32'd0, md_out}, 64'hCAFEBABE);
    op = OP_NONE; #1;
    check("none_md_out", {32'd0, md_out}, 64'd0);
    $display("seq mfhi/mflo checked");

    // mthi with cancel
    step();
    start = 1'b1; cancel = 1'b1; op = OP_MTHI; rs_val = 32'hDEADBEEF;
    step();
    start = 1'b0; cancel = 1'b0; op = OP_NONE;
    check("cancel_mthi_hi", {32'd0, hi}, 64'h12345678);
    $display("seq cancelled mthi hi=%h", hi);

    // mult with cancel, d_md_class high: no stall, no busy
    d_md_class = 1'b1;
    start = 1'b1; cancel = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd4;
    #1;
    check("cancel_mult_stall", {63'd0, stall_md}, 64'd0);
    step();
    start = 1'b0; cancel = 1'b0; op = OP_NONE; d_md_class = 1'b0;
    check("cancel_mult_busy", {63'd0, busy}, 64'd0);
    step();
    check("cancel_mult_hilo", {hi, lo}, {32'h12345678, 32'hCAFEBABE});
    $display("seq cancelled mult busy=%0d hi=%h lo=%h", busy, hi, lo);

    // unknown op with start
    start = 1'b1; op = 5'd9; rs_val = 32'h55555555;
    step();
    start = 1'b0; op = OP_NONE;
    check("unknown_op_busy", {63'd0, busy}, 64'd0);
    check("unknown_op_hilo", {hi, lo}, {32'h12345678, 32'hCAFEBABE});
    $display("seq unknown op hi=%h lo=%h", hi, lo);

    // second start while busy, plus cancel while busy: first op completes
    start = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd4;
    step();
    start = 1'b0; op = OP_NONE;
    step();
    start = 1'b1; op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
    step();
    start = 1'b0; op = OP_NONE; cancel = 1'b1;
    step();
    cancel = 1'b0;
    count_busy(n, stall_ok);
    check("busy_ignore_cycles", 64'(n + 3), 64'd5);
    check("busy_ignore_hilo", {hi, lo}, {32'h00000000, 32'h0000000C});
    step(); step();
    check("busy_ignore_idle", {63'd0, busy}, 64'd0);
    $display("seq start-while-busy total=%0d hi=%h lo=%h", n + 3, hi, lo);

    // div in flight, reset pulsed during its 4th busy cycle
    start = 1'b1; op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
    step();
    start = 1'b0; op = OP_NONE;
    step(); step(); step();
    check("reset_mid_busy_before", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset_mid_busy", {63'd0, busy}, 64'd0);
    check("reset_mid_hilo", {hi, lo}, 64'd0);
    #2;
    reset_n = 1'b1;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) n++;
    end
    check("reset_no_commit", 64'(n), 64'd0);
    $display("seq mid-op reset busy=%0d hi=%h lo=%h", busy, hi, lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_e_stage.md
Name: mdu_e_stage

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the decoder's MDU controls (start, op, class) plus forwarded rs/rt operands.
- Holds the architectural HI/LO registers and models multi-cycle latency with a busy counter.
- Supplies the mfhi/mflo read value to the E-result mux and a stall request to the hazard unit.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu.
- DIV_CYCLES, 10, busy duration for div/divu.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  MDUStart of the instruction currently in E.
- op  in  5  MDUOp of the instruction in E (encodings in package).
- d_md_class  in  1  MDUClass of the instruction in D, used for the stall request.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- cancel  in  1  exception/interrupt taken on the E instruction this cycle; suppresses its effect.
- busy  out  1  registered; high while a mult/div is in flight.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- md_out  out  32  combinational; hi when op==MFHI, lo when op==MFLO, else 0.
- stall_md  out  1  combinational; d_md_class & (busy | (start & is_muldiv(op) & ~cancel)).

Behaviour:
- Reset (async, reset_n low): hi=0, lo=0, busy=0, counter=0, pending result=0. Applies immediately, including mid-operation; the in-flight result is discarded.
- Accept condition: start & ~cancel & ~busy, sampled on the rising edge. start while busy is ignored (the hazard unit guarantees this never happens; the bench still checks it).
- MULT/MULTU at accept edge:
  - compute the 64-bit product into a pending register.
  - MULT: signed x signed. MULTU: zero-extended operands.
  - counter <= MULT_CYCLES; busy <= 1.
- DIV/DIVU at accept edge:
  - pending = {rs%rt, rs/rt}; DIV uses signed quotient truncated toward zero, remainder takes the dividend's sign.
  - counter <= DIV_CYCLES; busy <= 1.
  - rt_val==0: flag no-write; HI/LO are left unchanged at completion, but busy timing is identical.
- MTHI/MTLO at accept edge: hi<=rs_val or lo<=rs_val respectively; no busy.
- MFHI/MFLO: no state change; md_out reflects current hi/lo, same-cycle combinational.
- Counter/FSM: two states, IDLE and RUN.
  - RUN decrements the counter each edge.
  - On the edge where the counter goes 1->0: {hi,lo}<=pending (unless no-write), busy<=0, return to IDLE.
  - busy is high for exactly N cycles after the accept edge; the new HI/LO are visible in the cycle after busy falls.
- cancel with start in the same cycle: no state change at all (no busy, no mthi/mtlo write).
- cancel while busy: no effect; an accepted op always completes.
- Unknown op with start: ignored, no state change.

Decomposition:
- Shared package (extends the existing defines file):
  - MDU op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MFHI=4, MFLO=5, MTHI=6, MTLO=7.
  - Default latency constants.
- No sub-module. The 64-bit compute (mul/div operators) stays inline as a combinational always block; the counter FSM lives in the same module.

Test Plan:
- mult rs=0xFFFFFFFD (-3), rt=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu rs=0xFFFFFFFF, rt=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; during busy with d_md_class=1, stall_md=1 every cycle.
- div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7, rt=0 -> busy 10 cycles, hi/lo unchanged.
- mthi rs=0x12345678 then mfhi next cycle -> md_out=0x12345678 with no busy. Same mthi with cancel=1 -> hi unchanged.
- start mult with cancel=1 -> busy stays 0, hi/lo unchanged. A second start while busy -> ignored; the first result is committed.
- div in flight, reset_n pulsed low at cycle 4 -> busy=0, hi=lo=0 immediately. No commit occurs after reset release.
